// File: rtl/channel_sar_ctrl.sv
// rtl/channel_sar_ctrl.sv - per-channel trigger, sample/hold, SAR conversion and output register.
// Optional hit synchronizer: define CHANNEL_SAR_CTRL_HIT_SYNC_EN.
module channel_sar_ctrl #(
  parameter int ADCBITS       = 10,
  parameter int TS_BITS       = 24,
  parameter int SAMPLE_CYCLES = 2,
  parameter int RESET_CYCLES  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               hit,
  input  logic               ext_trigger,
  input  logic               comp,
  input  logic [TS_BITS-1:0] timestamp,
  output logic               sample,
  output logic               strobe,
  output logic               csa_reset,
  output logic [ADCBITS-1:0] dac_word,
  output logic [ADCBITS-1:0] adc_word,
  output logic [TS_BITS-1:0] ts_word,
  output logic               data_valid,
  input  logic               data_ready,
  output logic               busy
);

  typedef enum logic [2:0] {IDLE, SAMPLE, STROBE, DECIDE, WRITE, RESET_CSA} state_t;

  localparam int CNT_MAX = (SAMPLE_CYCLES > RESET_CYCLES) ? SAMPLE_CYCLES : RESET_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [ADCBITS-1:0] TRIAL_MSB = ADCBITS'(1) << (ADCBITS - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ADCBITS-1:0] result;
  logic [ADCBITS-1:0] trial;
  logic [TS_BITS-1:0] ts_cap;
  logic               hit_s;
  logic               trig;
  logic               load;
  logic [ADCBITS-1:0] res_upd;
  logic [ADCBITS-1:0] trial_nxt;

`ifdef CHANNEL_SAR_CTRL_HIT_SYNC_EN
  logic [1:0] hit_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_sync <= 2'b00;
    end else begin
      hit_sync <= {hit_sync[0], hit};
    end
  end

  assign hit_s = hit_sync[1];
`else
  assign hit_s = hit;
`endif

  assign trig      = enable & (hit_s | ext_trigger);
  assign load      = (state == WRITE) && (!data_valid || data_ready);
  assign res_upd   = comp ? (result | trial) : result;
  assign trial_nxt = trial >> 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RESET_CSA;
      cnt        <= CNT_W'(RESET_CYCLES - 1);
      result     <= '0;
      trial      <= '0;
      ts_cap     <= '0;
      sample     <= 1'b0;
      strobe     <= 1'b0;
      csa_reset  <= 1'b1;
      dac_word   <= '0;
      adc_word   <= '0;
      ts_word    <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b1;
    end else begin
      // A load on the same edge as a drain wins, so the register stays full.
      if (load) begin
        adc_word   <= result;
        ts_word    <= ts_cap;
        data_valid <= 1'b1;
      end else if (data_ready) begin
        data_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (trig) begin
            ts_cap <= timestamp;
            result <= '0;
            trial  <= TRIAL_MSB;
            cnt    <= CNT_W'(SAMPLE_CYCLES - 1);
            sample <= 1'b1;
            busy   <= 1'b1;
            state  <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (cnt == '0) begin
            sample   <= 1'b0;
            strobe   <= 1'b1;
            dac_word <= result | trial;
            state    <= STROBE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STROBE: begin
          strobe <= 1'b0;
          state  <= DECIDE;
        end
        DECIDE: begin
          result <= res_upd;
          trial  <= trial_nxt;
          if (trial[0]) begin
            dac_word <= '0;
            state    <= WRITE;
          end else begin
            strobe   <= 1'b1;
            dac_word <= res_upd | trial_nxt;
            state    <= STROBE;
          end
        end
        WRITE: begin
          if (load) begin
            csa_reset <= 1'b1;
            cnt       <= CNT_W'(RESET_CYCLES - 1);
            state     <= RESET_CSA;
          end
        end
        RESET_CSA: begin
          if (cnt == '0) begin
            csa_reset <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          csa_reset <= 1'b1;
          cnt       <= CNT_W'(RESET_CYCLES - 1);
          busy      <= 1'b1;
          state     <= RESET_CSA;
        end
      endcase
    end
  end

endmodule
